// File: rtl/capture_fifo.sv
// capture_fifo: small show-ahead synchronous FIFO that buffers producer words
// ahead of the variable-width pipeline register bank.
// Optional feature macro: CAPTURE_FIFO_ERR_FLAGS_EN builds sticky
// overflow/underflow flags; when undefined the flags are tied to 0.
module capture_fifo #(
    parameter int Width     = 8,
    parameter int AddrWidth = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [Width-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Width-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AddrWidth:0]   count,
    output logic                 overflow_err,
    output logic                 underflow_err,
    input  logic                 err_clr
);

    localparam int Depth = 1 << AddrWidth;

    localparam logic [AddrWidth:0]   CNT_FULL = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [AddrWidth:0]   CNT_ONE  = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] PTR_ONE  = {{(AddrWidth-1){1'b0}}, 1'b1};

    logic [Width-1:0]     r_mem [Depth];
    logic [AddrWidth-1:0] r_wr_ptr;
    logic [AddrWidth-1:0] r_rd_ptr;
    logic [AddrWidth:0]   r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_wr;
    logic w_rd;

    // Flags decode only from the registered count, so ready/valid never
    // depend combinationally on the other side's handshake inputs.
    assign w_in_ready  = (r_count != CNT_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_wr        = in_valid  && w_in_ready;
    assign w_rd        = out_ready && w_out_valid;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;
    // Show-ahead head word, forced to zero when empty so stale storage
    // (including words from before a reset) is never visible.
    assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;

    // Storage array: written on an accepted word, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers advance on their handshake and wrap naturally at Depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy: +1 write-only, -1 read-only, hold on both or neither.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CAPTURE_FIFO_ERR_FLAGS_EN
    logic r_overflow_err;
    logic r_underflow_err;

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (in_valid && !w_in_ready) begin
                r_overflow_err <= 1'b1;
            end else if (err_clr) begin
                r_overflow_err <= 1'b0;
            end
            if (out_ready && !w_out_valid) begin
                r_underflow_err <= 1'b1;
            end else if (err_clr) begin
                r_underflow_err <= 1'b0;
            end
        end
    end

    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;
`else
    // Feature disabled: ports kept for a uniform instantiation.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow_err     = 1'b0;
    assign underflow_err    = 1'b0;
`endif

endmodule

// File: tb/tb_capture_fifo.sv
// Testbench for capture_fifo (Width=8, Depth=4): table-driven vectors plus
// hand-written sequences for latency, pointer wrap and asynchronous reset.
module tb_capture_fifo;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow_err;
    logic       underflow_err;
    logic       err_clr;

    int total;
    int bad;

`ifdef CAPTURE_FIFO_ERR_FLAGS_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    capture_fifo #(.Width(8), .AddrWidth(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] e_cnt, input logic e_ov,
                            input logic [7:0] e_od, input logic e_ir);
        chk({tag, ".count"},     64'(count),     64'(e_cnt));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
        chk({tag, ".out_data"},  64'(out_data),  64'(e_od));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(e_ir));
    endtask

    // One cycle: drive at negedge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       clr;
        logic [2:0] cnt;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic       oe;
        logic       ue;
    } vec_t;

    vec_t tbl[13];
    logic [7:0] model_q[$];
    logic [7:0] exp_d;

    initial begin
        total = 0;
        bad   = 0;
        // inputs              iv  id     ordy clr | cnt  ov  od     ir  oe  ue
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        // full: read happens, write of 0x55 refused
        tbl[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 3'd3, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        // empty: write accepted, read refused (underflow)
        tbl[8]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        // clear and new underflow in the same cycle: set wins
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        reset_n   = 1'b0;
        #12;
        chk_outs("reset", 3'd0, 1'b0, 8'h00, 1'b1);
        chk("reset.ovf", 64'(overflow_err), 64'd0);
        chk("reset.unf", 64'(underflow_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk_outs("idle", 3'd0, 1'b0, 8'h00, 1'b1);

        // Table-driven fill, full collision, drain, empty collision, flags
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].clr);
            chk_outs($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].od, tbl[i].ir);
            chk($sformatf("vec%0d.ovf", i), 64'(overflow_err), 64'(ErrEn ? tbl[i].oe : 1'b0));
            chk($sformatf("vec%0d.unf", i), 64'(underflow_err), 64'(ErrEn ? tbl[i].ue : 1'b0));
        end

        // Latency: nothing visible before the write edge, visible right after
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #3;
        chk("lat.pre_valid", 64'(out_valid), 64'd0);
        chk("lat.pre_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        chk("lat.post_valid", 64'(out_valid), 64'd1);
        chk("lat.post_data", 64'(out_data), 64'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk_outs("lat.drain", 3'd0, 1'b0, 8'h00, 1'b1);

        // Steady count=2 streaming across two pointer wraps, checked
        // against a queue model
        model_q.delete();
        cycle(1'b1, 8'hE0, 1'b0, 1'b0);
        model_q.push_back(8'hE0);
        cycle(1'b1, 8'hE1, 1'b0, 1'b0);
        model_q.push_back(8'hE1);
        chk("wrap.pre_count", 64'(count), 64'd2);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            void'(model_q.pop_front());
            model_q.push_back(8'(i));
            exp_d = model_q[0];
            chk($sformatf("wrap%0d.count", i), 64'(count), 64'd2);
            chk($sformatf("wrap%0d.data", i), 64'(out_data), 64'(exp_d));
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap.tail1", 64'(out_data), 64'h09);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk_outs("wrap.empty", 3'd0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset in the middle of a burst with count=3
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        chk("arst.pre_count", 64'(count), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs("arst", 3'd0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk_outs("arst.after", 3'd0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        chk_outs("arst.fresh", 3'd1, 1'b1, 8'h7E, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
